mem_dma_initiator: RTL

//  Memory-bus initiator (bus master) that moves word blocks without the CPU.

---
 rtl/dma_pkg.sv | 26 ++
 rtl/mem_dma_initiator.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the memory-bus DMA initiator.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RD    = 3'd2,
    WR    = 3'd3,
    DONE  = 3'd4
  } dma_state_t;

  localparam logic DMA_MODE_COPY = 1'b0;
  localparam logic DMA_MODE_FILL = 1'b1;

  localparam logic [3:0] WMASK_NONE = 4'b0000;
  localparam logic [3:0] WMASK_WORD = 4'b1111;

  // Byte stride between consecutive words on the bus.
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // A bus byte address is word-aligned when its two low bits are clear.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_dma_initiator.sv
// Memory-bus initiator: COPY moves a word block from src to dst, FILL writes
// a constant word over a dst block. Every bus output is a flop, so nothing
// combinational reaches the bus from any input.
module mem_dma_initiator
  import dma_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_in,
  input  logic             mode_in,
  input  logic [31:0]      src_addr_in,
  input  logic [31:0]      dst_addr_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic [31:0]      fill_value_in,
  input  logic             abort_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             error_out,
  output logic [31:0]      address_out,
  output logic             sel_out,
  output logic [3:0]       write_mask_out,
  output logic [31:0]      write_value_out,
  input  logic [31:0]      read_value_in,
  input  logic             ready_in
);

  dma_state_t       state_q, state_d;
  logic             mode_q, mode_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [31:0]      buf_q, buf_d;
  logic [31:0]      fill_q, fill_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [31:0]      addr_q, addr_d;
  logic             sel_q, sel_d;
  logic [3:0]       mask_q, mask_d;
  logic [31:0]      wval_q, wval_d;

  // Next-state, datapath updates, and the bus image for the next state.
  always_comb begin
    // NOTE: every signal written here gets a default first; an unassigned
    // path through the case would otherwise infer a latch.
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    count_d = count_q;
    buf_d   = buf_q;
    fill_d  = fill_q;
    error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          mode_d  = mode_in;
          src_d   = src_addr_in;
          dst_d   = dst_addr_in;
          count_d = len_in;
          fill_d  = fill_value_in;
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (is_misaligned(dst_q) ||
            (mode_q == DMA_MODE_COPY && is_misaligned(src_q))) begin
          error_d = 1'b1;
          state_d = DONE;
        end else if (count_q == '0) begin
          state_d = DONE;
        end else if (mode_q == DMA_MODE_COPY) begin
          state_d = RD;
        end else begin
          state_d = WR;
        end
      end

      RD: begin
        if (ready_in) begin
          buf_d   = read_value_in;
          src_d   = src_q + WORD_BYTES;
          state_d = WR;
        end
        // A read completing on the abort edge is kept but never written.
        if (abort_in) state_d = DONE;
      end

      WR: begin
        if (ready_in) begin
          dst_d   = dst_q + WORD_BYTES;
          count_d = count_q - LEN_W'(1);
          if (count_d == '0)               state_d = DONE;
          else if (mode_q == DMA_MODE_COPY) state_d = RD;
        end
        // A write completing on the abort edge still lands.
        if (abort_in) state_d = DONE;
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus and status outputs describe the state being entered, so they are
    // registered alongside it and hold steady while a beat stalls.
    busy_d = state_d inside {CHECK, RD, WR};
    done_d = (state_d == DONE);
    sel_d  = state_d inside {RD, WR};
    mask_d = (state_d == WR) ? WMASK_WORD : WMASK_NONE;
    if (state_d == RD)      addr_d = src_d;
    else if (state_d == WR) addr_d = dst_d;
    else                    addr_d = '0;
    if (state_d == WR) wval_d = (mode_d == DMA_MODE_FILL) ? fill_d : buf_d;
    else               wval_d = '0;
  end

  // FSM, transfer registers and registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= DMA_MODE_COPY;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      // NOTE: the word buffer is a single register, not a RAM array, so it
      // is cleared on reset like the rest of the datapath.
      buf_q   <= '0;
      fill_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      addr_q  <= '0;
      sel_q   <= 1'b0;
      mask_q  <= WMASK_NONE;
      wval_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      wval_q  <= wval_d;
    end
  end

  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign error_out       = error_q;
  assign address_out     = addr_q;
  assign sel_out         = sel_q;
  assign write_mask_out  = mask_q;
  assign write_value_out = wval_q;

endmodule
